// File: rtl/right_shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle right shifter and the
// single-bit right_shift_register stage it feeds.
package right_shift_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Fill-mode encoding shared with right_shift_register users.
  localparam logic ModeArith = 1'b0;
  localparam logic ModeLogic = 1'b1;

endpackage

// File: rtl/right_shift_sequencer_if.sv
// Request/response bundle of the right shift sequencer; the requester holds
// the master modport and the sequencer holds the slave modport.
interface right_shift_sequencer_if #(
  parameter int unsigned width = 16,
  parameter int unsigned amt_w = 4
);

  logic             start;
  logic [width-1:0] data_in;
  logic [amt_w-1:0] shift_amt;
  logic             mode;
  logic             busy;
  logic             done;
  logic [width-1:0] result;

  modport master (
    output start,
    output data_in,
    output shift_amt,
    output mode,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  data_in,
    input  shift_amt,
    input  mode,
    output busy,
    output done,
    output result
  );

endinterface

// File: rtl/right_shift_sequencer_shift_down_counter.sv
// Loadable down counter that saturates at zero; last flags the final
// decrement so the owner can leave its counting state on that edge.
module shift_down_counter #(
  parameter int unsigned amt_w = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [amt_w-1:0] load_val,
  input  logic             dec,
  output logic [amt_w-1:0] count,
  output logic             last
);

  logic [amt_w-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - amt_w'(1);
    end
  end

  assign count = count_q;
  assign last  = (count_q == amt_w'(1));

endmodule

// File: rtl/right_shift_sequencer.sv
// Variable-distance arithmetic/logical right shifter that applies one bit of
// shift per clock and pulses done for one cycle when the word is complete.
module right_shift_sequencer
  import right_shift_sequencer_pkg::*;
#(
  parameter int unsigned width = 16,
  parameter int unsigned amt_w = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  right_shift_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [width-1:0] result_q;
  logic             mode_q;
  logic             accept;
  logic             fill;
  logic [amt_w-1:0] cnt;
  logic             cnt_last;

  // A start seen mid-shift is dropped; DONE accepts it as a back-to-back op.
  assign accept = bus.start && (state_q != StShift);

  shift_down_counter #(
    .amt_w (amt_w)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (bus.shift_amt),
    .dec      (state_q == StShift),
    .count    (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (bus.shift_amt == '0) ? StDone : StShift;
      end
      StShift: begin
        if (cnt_last) state_d = StDone;
      end
      StDone: begin
        if (accept) state_d = (bus.shift_amt == '0) ? StDone : StShift;
        else        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sign fill reads the live MSB, which still holds the original sign bit.
  assign fill = (mode_q == ModeArith) ? result_q[width-1] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      mode_q   <= ModeArith;
    end else if (accept) begin
      result_q <= bus.data_in;
      mode_q   <= bus.mode;
    end else if (state_q == StShift) begin
      result_q <= {fill, result_q[width-1:1]};
    end
  end

  assign bus.busy   = (state_q == StShift);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

  a_shift_count_nonzero: assert property (
    @(posedge clk) disable iff (reset) (state_q == StShift) |-> (cnt != '0)
  );

endmodule

// File: tb/tb_right_shift_sequencer.sv
// Directed-vector bench for right_shift_sequencer with hand-computed results.
module tb_right_shift_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  right_shift_sequencer_if #(.width(16), .amt_w(4)) bus ();

  right_shift_sequencer #(
    .width (16),
    .amt_w (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done should be high.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic m, input logic [15:0] exp);
    int nbusy;
    bus.start     = 1'b1;
    bus.data_in   = d;
    bus.shift_amt = a;
    bus.mode      = m;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.data_in   = ~d;
    bus.shift_amt = ~a;
    bus.mode      = ~m;
    nbusy = 0;
    while (bus.busy && nbusy < 40) begin
      nbusy++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, nbusy, 32'(a));
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_result"}, 32'(bus.result), 32'(exp));
  endtask

  task automatic post_check(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(bus.done), 0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 0);
    check({tag, "_held"}, 32'(bus.result), 32'(exp));
  endtask

  initial begin
    int ndone;
    total         = 0;
    bad           = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.data_in   = '0;
    bus.shift_amt = '0;
    bus.mode      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(bus.result), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    reset = 1'b0;
    @(negedge clk);

    run_op("arith4", 16'hF000, 4'd4, 1'b0, 16'hFF00);
    post_check("arith4", 16'hFF00);
    repeat (3) @(negedge clk);
    check("idle_hold", 32'(bus.result), 32'h0000FF00);

    run_op("logic4", 16'hF000, 4'd4, 1'b1, 16'h0F00);
    post_check("logic4", 16'h0F00);

    run_op("amt0", 16'h1234, 4'd0, 1'b0, 16'h1234);
    post_check("amt0", 16'h1234);

    run_op("arith15", 16'h8000, 4'd15, 1'b0, 16'hFFFF);
    post_check("arith15", 16'hFFFF);

    run_op("logic15", 16'h8000, 4'd15, 1'b1, 16'h0001);
    post_check("logic15", 16'h0001);

    run_op("neg16", 16'hFFF0, 4'd1, 1'b0, 16'hFFF8);
    post_check("neg16", 16'hFFF8);

    // Ignored mid-shift start, then reset abort.
    bus.start     = 1'b1;
    bus.data_in   = 16'h00FF;
    bus.shift_amt = 4'd8;
    bus.mode      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start     = 1'b1;
    bus.data_in   = 16'hAAAA;
    bus.shift_amt = 4'd2;
    bus.mode      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy", 32'(bus.busy), 1);
    check("ign_result", 32'(bus.result), 32'h001F);
    @(negedge clk);
    check("ign_result2", 32'(bus.result), 32'h000F);
    @(negedge clk);
    check("pre_rst_result", 32'(bus.result), 32'h0007);
    reset = 1'b1;
    #1;
    check("abort_result", 32'(bus.result), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 0);
    check("abort_idle", 32'(bus.busy), 0);

    run_op("after_rst", 16'hF000, 4'd4, 1'b0, 16'hFF00);
    // Start during the DONE cycle: no IDLE gap between operations.
    run_op("b2b", 16'h00F0, 4'd4, 1'b1, 16'h000F);
    post_check("b2b", 16'h000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/right_shift_sequencer.md
Name: right_shift_sequencer

Overview:
Multi-bit right shifter that sits directly upstream of the datapath's single-bit right_shift_register stage.
It accepts an operand, a shift amount and a mode, then applies one bit of shift per clock until the count is exhausted.
It produces the fully shifted word with a one-cycle done pulse, so downstream logic sees a variable-distance arithmetic or logical right shift.
Throughput is one operation per (amt+1) cycles; there is no barrel shifter.

Parameters:
width, 16, operand/result width in bits
amt_w, 4, shift-amount width; must equal $clog2(width)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on posedge, accepted only in IDLE or DONE
data_in  input  width  operand, captured on accepted start
shift_amt  input  amt_w  number of 1-bit shifts, 0..width-1, captured on accepted start
mode  input  1  0 = arithmetic (sign fill), 1 = logical (zero fill), captured on accepted start
busy  output  1  high while in SHIFT state
done  output  1  one-cycle pulse, high while in DONE state
result  output  width  working register; valid when done=1, held until next accepted start

Behaviour:
- Reset (async, active-high): state=IDLE, result=0, count=0, latched mode=0, busy=0, done=0. Reset mid-SHIFT aborts the operation immediately with no done pulse.
- States are IDLE, SHIFT and DONE; busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state.
- Accepted start (edge E0, state IDLE or DONE):
  - result <= data_in, count <= shift_amt, mode latched.
  - next state is DONE if shift_amt==0, else SHIFT.
- SHIFT, each edge:
  - result <= {fill, result[width-1:1]}, with fill = result[width-1] if latched mode==0, else 1'b0.
  - count <= count-1; when count==1 on this edge, next state is DONE.
- Latency: for amt=k≥1, k shifts occur on edges E1..Ek and done is high in the cycle after Ek; for amt=0, done is high in the cycle after E0.
- DONE lasts exactly one cycle, then goes to IDLE unless start is sampled, which is accepted as a back-to-back operation.
- start in SHIFT is ignored: no capture, no effect on count or result.
- Input changes on data_in, shift_amt or mode after capture have no effect.
- result is not modified in IDLE.
- Arithmetic fill replicates the original sign through all k shifts (e.g. -16 >>> 1 = -8). Logical fill inserts k zeros.
- shift_amt is unsigned. The maximum amount width-1 completes in width-1 shift cycles; count never wraps below 0.

Decomposition:
- Shared package: state typedef enum logic [1:0] {IDLE, SHIFT, DONE}; MODE_ARITH=1'b0 and MODE_LOGIC=1'b1 constants, shared with right_shift_register users.
- One natural sub-module: shift_down_counter (load, dec, count, last flag), parameterised by amt_w.
- The 1-bit shift step is kept inline in the sequencer.

Test Plan:
- width=16, data_in=16'hF000, amt=4, mode=0 -> busy high 4 cycles, then done pulse with result=16'hFF00.
- Same operand, amt=4, mode=1 -> result=16'h0F00 on done, same timing.
- data_in=16'h1234, amt=0 -> no busy cycle; done in the cycle after start with result=16'h1234.
- data_in=16'h8000, amt=15: mode=0 -> result=16'hFFFF; mode=1 -> result=16'h0001, done after 15 shift cycles.
- Start amt=8, pulse start with new data at shift cycle 3, assert reset at cycle 5:
  - the second start is ignored;
  - after reset, result=0, busy=0, done=0, and no done pulse follows;
  - a subsequent start works normally.
- Back-to-back: start asserted during the DONE cycle with data_in=16'h00F0, amt=4, mode=1 -> new operation accepted with no IDLE gap; second done gives result=16'h000F.
